// File: rtl/adc_seq_sar_ctrl.sv
// SAR ADC controller: clock-divided sequencer, per-channel averaging and a tagged
// {channel, result} FWFT FIFO between the analog macro and the bus wrapper.
module adc_seq_sar_ctrl #(
  parameter int RES      = 10,
  parameter int CH_W     = 3,
  parameter int SEQ_LEN  = 8,
  parameter int FIFO_AW  = 4,
  parameter int CLKDIV_W = 8,
  parameter int AVG_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [CLKDIV_W-1:0]         clkdiv,
  input  logic [3:0]                  swidth,
  input  logic [1:0]                  mode,
  input  logic                        start,
  input  logic [CH_W-1:0]             ch_sel,
  input  logic [SEQ_LEN*(CH_W+1)-1:0] seq_cfg,
  input  logic [AVG_W-1:0]            avg_sel,
  input  logic                        cmp,
  output logic                        sample_n,
  output logic [RES-1:0]              dac_code,
  output logic [CH_W-1:0]             ch_sel_out,
  output logic                        busy,
  output logic                        eoc,
  input  logic                        rd,
  output logic [CH_W+RES-1:0]         fifo_rdata,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [FIFO_AW:0]            fifo_level,
  input  logic [FIFO_AW:0]            fifo_threshold,
  output logic                        fifo_above,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  // state  | meaning
  // IDLE   | waiting for a pending start on a tick
  // SAMPLE | S/H switch closed for swidth+1 ticks
  // CONV   | RES ticks of successive approximation, MSB first
  // DONE   | accumulate code; repeat sample or emit result and advance step

  localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int ENT_W  = CH_W + 1;
  localparam int ACC_W  = RES + 2**AVG_W - 1;
  localparam int CNT_W  = 2**AVG_W;
  localparam int BIT_W  = (RES > 1) ? $clog2(RES) : 1;
  localparam int DEPTH  = 2**FIFO_AW;
  localparam int LVL_W  = FIFO_AW + 1;
  localparam int WORD_W = CH_W + RES;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONV, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CLKDIV_W-1:0] div_cnt;
  logic                tick;
  logic                pending, pending_nxt;
  logic [3:0]          tmr, tmr_nxt;
  logic [BIT_W-1:0]    bit_idx, bit_nxt;
  logic [RES-1:0]      dac_nxt;
  logic [CH_W-1:0]     ch_nxt;
  logic [STEP_W-1:0]   step, step_nxt, step_inc;
  logic [ACC_W-1:0]    acc, acc_nxt, acc_sum;
  logic [CNT_W-1:0]    smp_cnt, smp_nxt;
  logic [AVG_W-1:0]    avg_lat, avg_nxt;
  logic                eoc_nxt;
  logic                push;
  logic [WORD_W-1:0]   push_word;
  logic                seq_mode, final_smp;
  logic [ENT_W-1:0]    step_ent;
  logic [CH_W-1:0]     first_ch, next_ch;
  logic [RES-1:0]      avg_result;

  // Tick generator: down-counter reloaded with clkdiv, fires on terminal count.
  assign tick = en && (div_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     div_cnt <= '0;
    else if (!en)   div_cnt <= '0;
    else if (tick)  div_cnt <= clkdiv;
    else            div_cnt <= div_cnt - 1'b1;
  end

  assign seq_mode   = (mode == 2'b01) || (mode == 2'b10);
  assign step_ent   = seq_cfg[int'(step)*ENT_W +: ENT_W];
  assign step_inc   = (step == LAST_STEP) ? '0 : step + 1'b1;
  assign first_ch   = seq_cfg[CH_W-1:0];
  assign next_ch    = seq_cfg[int'(step_inc)*ENT_W +: CH_W];
  assign acc_sum    = acc + ACC_W'(dac_code);
  assign avg_result = RES'(acc_sum >> avg_lat);
  assign final_smp  = (smp_cnt == ((CNT_W'(1) << avg_lat) - CNT_W'(1)));

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    tmr_nxt     = tmr;
    bit_nxt     = bit_idx;
    dac_nxt     = dac_code;
    ch_nxt      = ch_sel_out;
    step_nxt    = step;
    acc_nxt     = acc;
    smp_nxt     = smp_cnt;
    avg_nxt     = avg_lat;
    eoc_nxt     = 1'b0;
    push        = 1'b0;
    push_word   = '0;

    if (!en) begin
      state_nxt   = S_IDLE;
      pending_nxt = 1'b0;
      tmr_nxt     = '0;
      bit_nxt     = '0;
      dac_nxt     = '0;
      step_nxt    = '0;
      acc_nxt     = '0;
      smp_nxt     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick && pending) begin
            pending_nxt = 1'b0;
            state_nxt   = S_SAMPLE;
            tmr_nxt     = swidth;
            dac_nxt     = '0;
            step_nxt    = '0;
            acc_nxt     = '0;
            smp_nxt     = '0;
            avg_nxt     = avg_sel;
            ch_nxt      = seq_mode ? first_ch : ch_sel;
          end else if (start) begin
            pending_nxt = 1'b1;
          end
        end

        S_SAMPLE: begin
          if (tick) begin
            if (tmr == '0) begin
              state_nxt = S_CONV;
              bit_nxt   = BIT_W'(RES - 1);
              dac_nxt   = RES'(1) << (RES - 1);
            end else begin
              tmr_nxt = tmr - 1'b1;
            end
          end
        end

        S_CONV: begin
          if (tick) begin
            if (!cmp) dac_nxt[bit_idx] = 1'b0;
            if (bit_idx == '0) begin
              state_nxt = S_DONE;
            end else begin
              dac_nxt[bit_idx - 1'b1] = 1'b1;
              bit_nxt                 = bit_idx - 1'b1;
            end
          end
        end

        S_DONE: begin
          if (tick) begin
            tmr_nxt = swidth;
            dac_nxt = '0;
            if (!final_smp) begin
              state_nxt = S_SAMPLE;
              acc_nxt   = acc_sum;
              smp_nxt   = smp_cnt + 1'b1;
            end else begin
              push      = 1'b1;
              push_word = {ch_sel_out, avg_result};
              eoc_nxt   = 1'b1;
              acc_nxt   = '0;
              smp_nxt   = '0;
              avg_nxt   = avg_sel;
              if (!seq_mode) begin
                state_nxt = S_IDLE;
                step_nxt  = '0;
              end else if (step_ent[CH_W] || (step == LAST_STEP)) begin
                step_nxt  = '0;
                ch_nxt    = first_ch;
                state_nxt = (mode == 2'b01) ? S_IDLE : S_SAMPLE;
              end else begin
                step_nxt  = step_inc;
                ch_nxt    = next_ch;
                state_nxt = S_SAMPLE;
              end
            end
          end
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      tmr        <= '0;
      bit_idx    <= '0;
      dac_code   <= '0;
      ch_sel_out <= '0;
      step       <= '0;
      acc        <= '0;
      smp_cnt    <= '0;
      avg_lat    <= '0;
      eoc        <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      tmr        <= tmr_nxt;
      bit_idx    <= bit_nxt;
      dac_code   <= dac_nxt;
      ch_sel_out <= ch_nxt;
      step       <= step_nxt;
      acc        <= acc_nxt;
      smp_cnt    <= smp_nxt;
      avg_lat    <= avg_nxt;
      eoc        <= eoc_nxt;
    end
  end

  assign busy     = (state != S_IDLE);
  assign sample_n = (state != S_SAMPLE);

  // Result FIFO; a pop in the same cycle frees the slot for a push on full.
  logic [WORD_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               do_push, do_pop, ovf_set;
  logic [LVL_W-1:0]   level_nxt;

  assign do_pop    = rd && !fifo_empty;
  assign do_push   = push && (!fifo_full || do_pop);
  assign ovf_set   = push && fifo_full && !do_pop;
  assign level_nxt = fifo_level + LVL_W'(do_push) - LVL_W'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_nxt;
      fifo_empty <= (level_nxt == '0);
      fifo_full  <= (level_nxt == LVL_W'(DEPTH));
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign fifo_rdata = mem[rd_ptr];
  assign fifo_above = (fifo_level > fifo_threshold);

endmodule
